uart_echo_bridge: RTL
=====================

# uart_echo_bridge

Parametrised bridge between the UART receive FIFO read port and the transmit FIFO write port. Pops received words, optionally transforms or line-buffers them, and pushes them into the transmit FIFO with single-cycle rd/wr strobes. Sits between the UART rx/tx FIFOs in the loopback/test path and provides selectable modes, a transmit counter and an overflow flag.

## Interface
- DATA_BITS, 8, word width of both FIFOs (must be >= 8)
- BUF_DEPTH, 16, line-buffer depth in words (power of two, >= 2)
- TERM, 8'h0D, line terminator value (zero-extended to DATA_BITS)
- CNT_BITS, 16, width of tx_count
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- r_data  input  DATA_BITS  rx FIFO head word, valid while rx_empty=0 (first-word-fall-through)
- rx_empty  input  1  rx FIFO empty
- tx_full  input  1  tx FIFO full
- mode  input  2  00 echo, 01 uppercase echo, 10 line mode, 11 disabled
- w_data  output  DATA_BITS  word to tx FIFO, valid while wr=1
- rd  output  1  one-cycle pop strobe to rx FIFO
- wr  output  1  one-cycle push strobe to tx FIFO
- busy  output  1  high whenever state is not IDLE
- tx_count  output  CNT_BITS  words pushed since reset, wraps to 0
- ovf  output  1  sticky: line buffer filled without terminator

## Operation
- States: IDLE, SEND, STORE, FLUSH. All outputs registered; rd and wr default to 0 every cycle.
- Reset: state IDLE, rd=0, wr=0, w_data=0, busy=0, tx_count=0, ovf=0, line count=0, read pointer=0. Buffer contents not reset.
- mode sampled only in IDLE; changes in other states take effect on the next IDLE.
- IDLE, mode 11: stay; rd=wr=0; rx data remains in FIFO.
- IDLE, mode 00/01/10, line count>0 and mode!=10: go FLUSH (partial line is never lost on mode change).
- IDLE, mode 00/01, rx_empty=0: hold<=r_data, rd<=1, go SEND.
- IDLE, mode 10, rx_empty=0: hold<=r_data, rd<=1, go STORE.
- SEND: wait while tx_full=1. When tx_full=0: w_data<=hold (mode 01: if hold in 0x61..0x7A, hold-0x20; otherwise unchanged), wr<=1, tx_count++, go IDLE.
- STORE: buf[count]<=hold, count++. If hold==TERM go FLUSH; else if count+1==BUF_DEPTH, ovf<=1, go FLUSH; else go IDLE.
- FLUSH: each cycle with tx_full=0: w_data<=buf[rptr], wr<=1, tx_count++, rptr++. After word count-1 is pushed: count<=0, rptr<=0, go IDLE. tx_full=1 stalls without pushing. Words leave in arrival order, terminator included.
- Uppercase transform uses the full DATA_BITS value for the range compare.
- tx_count wraps from 2^CNT_BITS-1 to 0. ovf cleared only by reset.

## Timing
- Echo latency: rx_empty low sampled at edge N -> rd high in cycle N+1 -> wr high in cycle N+2 (tx_full=0). Sustained echo throughput: one word per 2 cycles.
- rx_empty is next sampled in the cycle wr is high, after the FIFO has applied the pop; no double-pop on a single word.
- rd never high for two consecutive cycles; rd and wr never high in the same cycle.
- Line mode: one word stored per 2 cycles; FLUSH pushes one word per cycle while tx_full=0, so an n-word line drains in n cycles plus stall cycles.
- tx_full rising in SEND/FLUSH: no wr that cycle; data and pointer held until tx_full=0.
- reset_n low mid-SEND/FLUSH: immediate return to reset values; a held or buffered word is discarded.

## Test plan
- Mode 00, push 0x41,0x62 into rx FIFO, tx_full=0 -> tx receives 0x41,0x62; wr two cycles after each rx_empty fall; tx_count=2.
- Mode 01, send 0x61,0x7A,0x7B,0x5A -> tx receives 0x41,0x5A,0x7B,0x5A.
- Mode 10, send 0x48,0x49,0x0D -> no wr until 0x0D stored, then 0x48,0x49,0x0D on three consecutive cycles; ovf=0.
- Mode 10, send 16 words without 0x0D -> ovf=1, 16 words flushed in order; 17th word starts a new line.
- Echo with tx_full held high 5 cycles in SEND -> wr stays 0, then exactly one push of the held word, no rx loss.
- Mode 10 with 2 words buffered, switch to 00 -> both words flushed before next echo; reset_n low mid-FLUSH -> all outputs 0, count 0.

Source files
------------

// File: rtl/uart_echo_bridge.sv
// Bridge from the UART rx FIFO read port to the tx FIFO write port: plain echo,
// uppercase echo or line-buffered loopback, with a tx word counter and overflow flag.
module uart_echo_bridge #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned BUF_DEPTH = 16,
  parameter logic [7:0]  TERM      = 8'h0D,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] r_data,
  input  logic                 rx_empty,
  input  logic                 tx_full,
  input  logic [1:0]           mode,
  output logic [DATA_BITS-1:0] w_data,
  output logic                 rd,
  output logic                 wr,
  output logic                 busy,
  output logic [CNT_BITS-1:0]  tx_count,
  output logic                 ovf
);

  localparam int unsigned PTR_BITS = $clog2(BUF_DEPTH);
  localparam int unsigned LEN_BITS = PTR_BITS + 1;

  localparam logic [LEN_BITS-1:0]  LINE_FULL = LEN_BITS'(BUF_DEPTH);
  localparam logic [DATA_BITS-1:0] TERM_W    = DATA_BITS'(TERM);
  localparam logic [DATA_BITS-1:0] LOWER_A   = DATA_BITS'(8'h61);
  localparam logic [DATA_BITS-1:0] LOWER_Z   = DATA_BITS'(8'h7A);
  localparam logic [DATA_BITS-1:0] CASE_OFF  = DATA_BITS'(8'h20);

  localparam logic [1:0] MODE_UPPER = 2'b01;
  localparam logic [1:0] MODE_LINE  = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  typedef enum logic [1:0] {IDLE, SEND, STORE, FLUSH} state_e;

  state_e                 state_q,    state_d;
  logic [DATA_BITS-1:0]   hold_q,     hold_d;
  logic                   upper_q,    upper_d;
  logic                   rd_q,       rd_d;
  logic                   wr_q,       wr_d;
  logic [DATA_BITS-1:0]   w_data_q,   w_data_d;
  logic                   busy_q,     busy_d;
  logic [CNT_BITS-1:0]    tx_count_q, tx_count_d;
  logic                   ovf_q,      ovf_d;
  logic [LEN_BITS-1:0]    count_q,    count_d;
  logic [PTR_BITS-1:0]    rptr_q,     rptr_d;
  logic                   buf_we;

  logic [DATA_BITS-1:0]   line_buf_q [BUF_DEPTH];

  function automatic logic [DATA_BITS-1:0] to_upper(input logic [DATA_BITS-1:0] c);
    return (c >= LOWER_A && c <= LOWER_Z) ? c - CASE_OFF : c;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    hold_d     = hold_q;
    upper_d    = upper_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    w_data_d   = w_data_q;
    tx_count_d = tx_count_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    rptr_d     = rptr_q;
    buf_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A partial line always drains before echoing resumes in another mode.
        if (mode != MODE_OFF) begin
          if (count_q != '0 && mode != MODE_LINE) begin
            state_d = FLUSH;
          end else if (!rx_empty) begin
            hold_d  = r_data;
            rd_d    = 1'b1;
            upper_d = (mode == MODE_UPPER);
            state_d = (mode == MODE_LINE) ? STORE : SEND;
          end
        end
      end

      SEND: begin
        if (!tx_full) begin
          w_data_d   = upper_q ? to_upper(hold_q) : hold_q;
          wr_d       = 1'b1;
          tx_count_d = tx_count_q + CNT_BITS'(1);
          state_d    = IDLE;
        end
      end

      STORE: begin
        buf_we  = 1'b1;
        count_d = count_q + LEN_BITS'(1);
        if (hold_q == TERM_W) begin
          state_d = FLUSH;
        end else if (count_q + LEN_BITS'(1) == LINE_FULL) begin
          ovf_d   = 1'b1;
          state_d = FLUSH;
        end else begin
          state_d = IDLE;
        end
      end

      FLUSH: begin
        if (!tx_full) begin
          w_data_d   = line_buf_q[rptr_q];
          wr_d       = 1'b1;
          tx_count_d = tx_count_q + CNT_BITS'(1);
          if ({1'b0, rptr_q} == count_q - LEN_BITS'(1)) begin
            count_d = '0;
            rptr_d  = '0;
            state_d = IDLE;
          end else begin
            rptr_d  = rptr_q + PTR_BITS'(1);
          end
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      upper_q    <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      tx_count_q <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      upper_q    <= upper_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      w_data_q   <= w_data_d;
      busy_q     <= busy_d;
      tx_count_q <= tx_count_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
    end
  end

  // NOTE: the line buffer has no reset; count_q/rptr_q guard every read, so stale words are never sent.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf_q[count_q[PTR_BITS-1:0]] <= hold_q;
    end
  end

  assign w_data   = w_data_q;
  assign rd       = rd_q;
  assign wr       = wr_q;
  assign busy     = busy_q;
  assign tx_count = tx_count_q;
  assign ovf      = ovf_q;

endmodule
